// File: rtl/vga_anim_scheduler.sv
// -----------------------------------------------------------------------------
// vga_anim_scheduler
// Frame-synchronous animation controller. On the start of vertical blanking
// (once every FRAME_DIV frames) it advances the animation time, the bouncing
// QR sprite position and the four Worley feature points. The values are worked
// out one after another into shadow registers, using a single shared add/sub
// unit, and then all outputs commit together in one cycle. The picture can
// therefore never show a half-updated set of values.
//
// Ports
//   clk         in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   counter_x   in   VGA horizontal counter
//   counter_y   in   VGA vertical counter
//   pause       in   1 = hold animation; updates come only from step
//   step        in   single-cycle request for one update while paused
//   qr_x, qr_y  out  QR sprite top-left position
//   tm          out  animation time (number of updates, 20-bit wrapping)
//   pt_x, pt_y  out  feature point coordinates, 4 entries of 9 bits each
//   frame_tick  out  single-cycle pulse in the cycle new values first appear
//   busy        out  high while an update sequence is in flight
// -----------------------------------------------------------------------------
module vga_anim_scheduler #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int QR_SIZE   = 54,
  parameter int FRAME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  counter_x,
  input  logic [9:0]  counter_y,
  input  logic        pause,
  input  logic        step,
  output logic [9:0]  qr_x,
  output logic [9:0]  qr_y,
  output logic [19:0] tm,
  output logic [8:0]  pt_x [0:3],
  output logic [8:0]  pt_y [0:3],
  output logic        frame_tick,
  output logic        busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADV_T  = 3'd1;
  localparam logic [2:0] BOUNCE = 3'd2;
  localparam logic [2:0] CALC   = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  localparam logic [9:0] X_MAX  = 10'(H_RES - QR_SIZE);
  localparam logic [9:0] Y_MAX  = 10'(V_RES - QR_SIZE);
  localparam logic [9:0] V_TRIG = 10'(V_RES);

  localparam int              DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  // Feature points at t = 0.
  localparam logic [8:0] PTX_RST [0:3] = '{9'd100, 9'd300, 9'd500, 9'd100};
  localparam logic [8:0] PTY_RST [0:3] = '{9'd100, 9'd200, 9'd400, 9'd500};

  // One bounce step on one axis: returns {dir_inc, position}. Reaching the
  // edge costs one update with the position held while the direction flips.
  function automatic logic [10:0] bounce_step(input logic [9:0] pos,
                                              input logic       inc,
                                              input logic [9:0] max_pos);
    logic [10:0] r;
    if (inc) begin
      if (pos >= max_pos) r = {1'b0, pos};
      else                r = {1'b1, pos + 10'd1};
    end else begin
      if (pos == 10'd0)   r = {1'b1, pos};
      else                r = {1'b0, pos - 10'd1};
    end
    return r;
  endfunction

  // Control state
  logic [2:0]       state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pend_q, pend_d;

  // Committed (visible) state
  logic [19:0] tm_q;
  logic [9:0]  qr_x_q, qr_y_q;
  logic        dir_x_q, dir_y_q;
  logic [8:0]  pt_x_q [0:3];
  logic [8:0]  pt_y_q [0:3];
  logic        tick_q;

  // Shadow state, built up during the update sequence
  logic [19:0] t_sh_q;
  logic [9:0]  qx_sh_q, qy_sh_q;
  logic        dx_sh_q, dy_sh_q;
  logic [8:0]  ptx_sh_q [0:3];
  logic [8:0]  pty_sh_q [0:3];

  logic        trigger_s, start_s;
  logic [19:0] add_a_s, add_b_s, add_y_s;
  logic        add_sub_s;
  logic [10:0] bx_s, by_s;

  assign trigger_s = (counter_y == V_TRIG) && (counter_x == 10'd0);
  // A trigger while busy is ignored entirely (divider included).
  assign start_s   = trigger_s && (state_q == IDLE) && (div_q == DIV_LAST) &&
                     (!pause || step || pend_q);

  assign bx_s = bounce_step(qr_x_q, dir_x_q, X_MAX);
  assign by_s = bounce_step(qr_y_q, dir_y_q, Y_MAX);

  // Next-state logic for the sequencer, frame divider and pending step.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    div_d   = div_q;
    pend_d  = pend_q;

    if (trigger_s && (state_q == IDLE)) begin
      if (div_q == DIV_LAST) div_d = '0;
      else                   div_d = div_q + DIV_W'(1);
    end else begin
      div_d = div_q;
    end

    // A step that arrives together with a qualifying trigger is consumed there.
    if (start_s)            pend_d = 1'b0;
    else if (step && pause) pend_d = 1'b1;
    else                    pend_d = pend_q;

    case (state_q)
      IDLE: begin
        k_d = 3'd0;
        if (start_s) state_d = ADV_T;
        else         state_d = IDLE;
      end
      ADV_T:  state_d = BOUNCE;
      BOUNCE: begin
        state_d = CALC;
        k_d     = 3'd0;
      end
      CALC: begin
        if (k_q == 3'd7) begin
          state_d = COMMIT;
          k_d     = 3'd0;
        end else begin
          state_d = CALC;
          k_d     = k_q + 3'd1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand selection for the shared add/sub unit (time advance, then k = 0..7).
  always_comb begin
    add_a_s   = 20'd0;
    add_b_s   = 20'd0;
    add_sub_s = 1'b0;
    case (state_q)
      ADV_T: begin
        add_a_s = tm_q;
        add_b_s = 20'd1;
      end
      CALC: begin
        case (k_q)
          3'd0: begin add_a_s = 20'd100; add_b_s = t_sh_q;        add_sub_s = 1'b0; end
          3'd1: begin add_a_s = 20'd100; add_b_s = t_sh_q;        add_sub_s = 1'b1; end
          3'd2: begin add_a_s = 20'd300; add_b_s = t_sh_q >> 1;   add_sub_s = 1'b1; end
          3'd3: begin add_a_s = 20'd200; add_b_s = t_sh_q >> 1;   add_sub_s = 1'b0; end
          3'd4: begin add_a_s = 20'd500; add_b_s = t_sh_q >> 1;   add_sub_s = 1'b0; end
          3'd5: begin add_a_s = 20'd400; add_b_s = t_sh_q >> 4;   add_sub_s = 1'b1; end
          3'd6: begin add_a_s = 20'd100; add_b_s = t_sh_q >> 3;   add_sub_s = 1'b1; end
          3'd7: begin add_a_s = 20'd500; add_b_s = t_sh_q >> 2;   add_sub_s = 1'b1; end
          default: begin add_a_s = 20'd0; add_b_s = 20'd0;        add_sub_s = 1'b0; end
        endcase
      end
      default: begin
        add_a_s   = 20'd0;
        add_b_s   = 20'd0;
        add_sub_s = 1'b0;
      end
    endcase
    if (add_sub_s) add_y_s = add_a_s - add_b_s;
    else           add_y_s = add_a_s + add_b_s;
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      div_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
    end
  end

  // Shadow registers: filled step by step, never visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_sh_q  <= 20'd0;
      qx_sh_q <= 10'd0;
      qy_sh_q <= 10'd0;
      dx_sh_q <= 1'b1;
      dy_sh_q <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        ptx_sh_q[i] <= PTX_RST[i];
        pty_sh_q[i] <= PTY_RST[i];
      end
    end else begin
      case (state_q)
        ADV_T: t_sh_q <= add_y_s;
        BOUNCE: begin
          dx_sh_q <= bx_s[10];
          qx_sh_q <= bx_s[9:0];
          dy_sh_q <= by_s[10];
          qy_sh_q <= by_s[9:0];
        end
        CALC: begin
          // Odd k produce y, even k produce x; k[2:1] selects the point.
          if (k_q[0]) pty_sh_q[k_q[2:1]] <= add_y_s[8:0];
          else        ptx_sh_q[k_q[2:1]] <= add_y_s[8:0];
        end
        default: t_sh_q <= t_sh_q;
      endcase
    end
  end

  // Visible registers: change only in the single COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm_q    <= 20'd0;
      qr_x_q  <= 10'd0;
      qr_y_q  <= 10'd0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      tick_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pt_x_q[i] <= PTX_RST[i];
        pt_y_q[i] <= PTY_RST[i];
      end
    end else if (state_q == COMMIT) begin
      tm_q    <= t_sh_q;
      qr_x_q  <= qx_sh_q;
      qr_y_q  <= qy_sh_q;
      dir_x_q <= dx_sh_q;
      dir_y_q <= dy_sh_q;
      tick_q  <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        pt_x_q[i] <= ptx_sh_q[i];
        pt_y_q[i] <= pty_sh_q[i];
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign qr_x       = qr_x_q;
  assign qr_y       = qr_y_q;
  assign tm         = tm_q;
  assign frame_tick = tick_q;
  assign busy       = (state_q != IDLE);

  for (genvar g = 0; g < 4; g++) begin : g_pt_out
    assign pt_x[g] = pt_x_q[g];
    assign pt_y[g] = pt_y_q[g];
  end

endmodule

// File: tb/tb_vga_anim_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_anim_scheduler
// Self-checking bench for vga_anim_scheduler. Frames are compressed: each one
// is a trigger cycle, a short stretch of randomised blanking cycles and a few
// randomised active-area cycles. The reference model works in terms of the
// number of updates performed: time, QR positions (a triangle wave) and the
// feature points are all closed-form functions of that count. A second
// instance with FRAME_DIV = 3 runs unpaused alongside the first.
// -----------------------------------------------------------------------------
module tb_vga_anim_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  cx, cy;
  logic        pause, step;

  logic [9:0]  qr_x, qr_y;
  logic [19:0] tm;
  logic [8:0]  pt_x [0:3];
  logic [8:0]  pt_y [0:3];
  logic        frame_tick, busy;

  logic [9:0]  d3_qr_x, d3_qr_y;
  logic [19:0] d3_tm;
  logic [8:0]  d3_pt_x [0:3];
  logic [8:0]  d3_pt_y [0:3];
  logic        d3_tick, d3_busy;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_n;        // updates done by dut
  int m_pend;     // step pending in dut
  int trig3;      // triggers seen by dut3 since reset
  int m3_n;       // updates done by dut3
  int tick3_seen; // frame ticks observed on dut3

  always #5 clk = ~clk;

  vga_anim_scheduler #(.FRAME_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .counter_x(cx), .counter_y(cy),
    .pause(pause), .step(step),
    .qr_x(qr_x), .qr_y(qr_y), .tm(tm), .pt_x(pt_x), .pt_y(pt_y),
    .frame_tick(frame_tick), .busy(busy)
  );

  vga_anim_scheduler #(.FRAME_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .counter_x(cx), .counter_y(cy),
    .pause(1'b0), .step(1'b0),
    .qr_x(d3_qr_x), .qr_y(d3_qr_y), .tm(d3_tm), .pt_x(d3_pt_x), .pt_y(d3_pt_y),
    .frame_tick(d3_tick), .busy(d3_busy)
  );

  // Bouncing position after n updates: 0..mx, held once at mx, down to 0, held once.
  function automatic int tri_pos(input int n, input int mx);
    int m;
    m = n % (2 * (mx + 1));
    return (m <= mx) ? m : (2 * mx + 1 - m);
  endfunction

  // Feature point coordinate for animation time t, mod 512.
  function automatic int exp_pt(input int idx, input bit is_y, input int t);
    int v;
    case ({idx[1:0], is_y})
      3'b000:  v = 100 + t;
      3'b001:  v = 100 - t;
      3'b010:  v = 300 - (t >> 1);
      3'b011:  v = 200 + (t >> 1);
      3'b100:  v = 500 + (t >> 1);
      3'b101:  v = 400 - (t >> 4);
      3'b110:  v = 100 - (t >> 3);
      default: v = 500 - (t >> 2);
    endcase
    return v & 511;
  endfunction

  function automatic void model_reset();
    m_n    = 0;
    m_pend = 0;
    trig3  = 0;
    m3_n   = 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One compressed frame: trigger, 13 blanking cycles, 3 active cycles.
  task automatic do_frame(input bit step_trig);
    bit upd, upd3;
    int old_n, new_n, e_n, e3_n, t;
    logic [19:0] e_tm;
    @(negedge clk);
    cx = 10'd0;
    cy = 10'd480;
    step = step_trig;
    upd   = !pause || step_trig || (m_pend != 0);
    upd3  = ((trig3 + 1) % 3) == 0;
    old_n = m_n;
    new_n = upd ? m_n + 1 : m_n;
    @(negedge clk);
    step = 1'b0;
    cy = 10'(481 + $urandom_range(43));
    cx = 10'($urandom_range(799));
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk);
      #1;
      e_n  = (c >= 11) ? new_n : old_n;
      e_tm = e_n[19:0];
      t    = e_n & 20'hFFFFF;
      checks++;
      if (frame_tick !== (upd && c == 11)) begin
        errors++;
        $display("FAIL frame_tick cyc=%0d got=%b want=%b", c, frame_tick, (upd && c == 11));
      end
      checks++;
      if (busy !== (upd && c <= 10)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b want=%b", c, busy, (upd && c <= 10));
      end
      checks++;
      if (tm !== e_tm) begin
        errors++;
        $display("FAIL tm cyc=%0d got=%0d want=%0d", c, tm, e_tm);
      end
      checks++;
      if (qr_x !== 10'(tri_pos(e_n, 586)) || qr_y !== 10'(tri_pos(e_n, 426))) begin
        errors++;
        $display("FAIL qr cyc=%0d got=(%0d,%0d) want=(%0d,%0d)", c, qr_x, qr_y,
                 tri_pos(e_n, 586), tri_pos(e_n, 426));
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pt_x[i] !== 9'(exp_pt(i, 1'b0, t)) || pt_y[i] !== 9'(exp_pt(i, 1'b1, t))) begin
          errors++;
          $display("FAIL pt[%0d] cyc=%0d got=(%0d,%0d) want=(%0d,%0d)", i, c, pt_x[i], pt_y[i],
                   exp_pt(i, 1'b0, t), exp_pt(i, 1'b1, t));
        end
      end
      e3_n = (c >= 11 && upd3) ? m3_n + 1 : m3_n;
      checks++;
      if (d3_tick !== (upd3 && c == 11)) begin
        errors++;
        $display("FAIL div3_tick cyc=%0d got=%b want=%b", c, d3_tick, (upd3 && c == 11));
      end
      checks++;
      if (d3_tm !== e3_n[19:0]) begin
        errors++;
        $display("FAIL div3_tm cyc=%0d got=%0d want=%0d", c, d3_tm, e3_n);
      end
      if (d3_tick === 1'b1) tick3_seen++;
    end
    m_n = new_n;
    if (upd) m_pend = 0;
    trig3++;
    if (upd3) m3_n++;
    // Active-area cycles: nothing may move.
    for (int a = 0; a < 3; a++) begin
      @(negedge clk);
      cx = 10'($urandom_range(639));
      cy = 10'($urandom_range(479));
      @(posedge clk);
      #1;
      e_tm = m_n[19:0];
      checks++;
      if (frame_tick !== 1'b0 || tm !== e_tm || qr_x !== 10'(tri_pos(m_n, 586)) ||
          pt_y[0] !== 9'(exp_pt(0, 1'b1, m_n & 20'hFFFFF))) begin
        errors++;
        $display("FAIL active_stable tick=%b tm=%0d qr_x=%0d pty0=%0d want tm=%0d", frame_tick,
                 tm, qr_x, pt_y[0], e_tm);
      end
    end
  endtask

  task automatic step_pulse();
    @(negedge clk);
    cx = 10'($urandom_range(639));
    cy = 10'($urandom_range(479));
    step = 1'b1;
    if (pause) m_pend = 1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pause = 1'b0;
    step  = 1'b0;
    cx    = 10'd0;
    cy    = 10'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (tm !== 20'd0 || qr_x !== 10'd0 || qr_y !== 10'd0 || frame_tick !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state tm=%0d qr=(%0d,%0d) tick=%b busy=%b", tm, qr_x, qr_y, frame_tick, busy);
    end
    checks++;
    if (pt_x[0] !== 9'd100 || pt_x[1] !== 9'd300 || pt_x[2] !== 9'd500 || pt_x[3] !== 9'd100 ||
        pt_y[0] !== 9'd100 || pt_y[1] !== 9'd200 || pt_y[2] !== 9'd400 || pt_y[3] !== 9'd500) begin
      errors++;
      $display("FAIL reset_pts got x={%0d,%0d,%0d,%0d} y={%0d,%0d,%0d,%0d}", pt_x[0], pt_x[1],
               pt_x[2], pt_x[3], pt_y[0], pt_y[1], pt_y[2], pt_y[3]);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (5) begin
      @(posedge clk);
      #1;
      checks++;
      if (frame_tick !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset tick=%b busy=%b want 0,0", frame_tick, busy);
      end
    end
  endtask

  task automatic test_first_frame();
    do_frame(1'b0);
    checks++;
    if (tm !== 20'd1 || qr_x !== 10'd1 || qr_y !== 10'd1) begin
      errors++;
      $display("FAIL first_frame tm=%0d qr=(%0d,%0d) want 1,(1,1)", tm, qr_x, qr_y);
    end
    checks++;
    if (pt_x[0] !== 9'd101 || pt_x[1] !== 9'd300 || pt_x[2] !== 9'd500 || pt_x[3] !== 9'd100 ||
        pt_y[0] !== 9'd99 || pt_y[1] !== 9'd200 || pt_y[2] !== 9'd400 || pt_y[3] !== 9'd500) begin
      errors++;
      $display("FAIL first_pts got x0=%0d y0=%0d want 101,99", pt_x[0], pt_y[0]);
    end
  endtask

  task automatic test_long_run();
    while (m_n < 200) do_frame(1'b0);
    checks++;
    if (tm !== 20'd200 || pt_x[0] !== 9'd300 || pt_y[0] !== 9'd412 ||
        pt_x[1] !== 9'd200 || pt_y[3] !== 9'd450) begin
      errors++;
      $display("FAIL frame200 tm=%0d x0=%0d y0=%0d x1=%0d y3=%0d want 200,300,412,200,450",
               tm, pt_x[0], pt_y[0], pt_x[1], pt_y[3]);
    end
    while (m_n < 588) begin
      do_frame(1'b0);
      if (m_n == 426 || m_n == 427 || m_n == 428) begin
        checks++;
        if (qr_y !== ((m_n == 428) ? 10'd425 : 10'd426)) begin
          errors++;
          $display("FAIL qr_y_peak n=%0d got=%0d", m_n, qr_y);
        end
      end
      if (m_n == 586 || m_n == 587 || m_n == 588) begin
        checks++;
        if (qr_x !== ((m_n == 588) ? 10'd585 : 10'd586)) begin
          errors++;
          $display("FAIL qr_x_peak n=%0d got=%0d", m_n, qr_x);
        end
      end
    end
  endtask

  task automatic test_pause_step();
    logic [19:0] base;
    base  = tm;
    pause = 1'b1;
    repeat (5) do_frame(1'b0);
    checks++;
    if (tm !== base) begin
      errors++;
      $display("FAIL paused_hold tm=%0d want=%0d", tm, base);
    end
    step_pulse();
    do_frame(1'b0);
    do_frame(1'b0);
    checks++;
    if (tm !== base + 20'd1) begin
      errors++;
      $display("FAIL step_once tm=%0d want=%0d", tm, base + 20'd1);
    end
    do_frame(1'b1);
    do_frame(1'b0);
    checks++;
    if (tm !== base + 20'd2) begin
      errors++;
      $display("FAIL step_at_trigger tm=%0d want=%0d", tm, base + 20'd2);
    end
    pause = 1'b0;
    step_pulse();
    do_frame(1'b0);
    pause = 1'b1;
    do_frame(1'b0);
    checks++;
    if (tm !== base + 20'd3) begin
      errors++;
      $display("FAIL step_unpaused_ignored tm=%0d want=%0d", tm, base + 20'd3);
    end
    pause = 1'b0;
  endtask

  task automatic test_skip_line();
    logic [19:0] base;
    base = tm;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      cy = (c < 8) ? 10'd480 : 10'd500;
      cx = 10'(1 + $urandom_range(700));
      @(posedge clk);
      #1;
      checks++;
      if (frame_tick !== 1'b0 || busy !== 1'b0 || d3_tick !== 1'b0 || tm !== base) begin
        errors++;
        $display("FAIL skipped_trigger tick=%b busy=%b d3_tick=%b tm=%0d want=%0d",
                 frame_tick, busy, d3_tick, tm, base);
      end
    end
  endtask

  task automatic test_frame_div();
    do_reset();
    tick3_seen = 0;
    repeat (6) do_frame(1'b0);
    checks++;
    if (tick3_seen != 2 || d3_tm !== 20'd2 || tm !== 20'd6) begin
      errors++;
      $display("FAIL frame_div ticks=%0d d3_tm=%0d tm=%0d want 2,2,6", tick3_seen, d3_tm, tm);
    end
  endtask

  task automatic test_reset_mid_update();
    @(negedge clk);
    cx = 10'd0;
    cy = 10'd480;
    @(negedge clk);
    cx = 10'd1;
    cy = 10'd500;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_abort got=%b want=1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tm !== 20'd0 || qr_x !== 10'd0 || qr_y !== 10'd0 || busy !== 1'b0 || frame_tick !== 1'b0 ||
        pt_x[0] !== 9'd100 || pt_y[3] !== 9'd500 || d3_tm !== 20'd0) begin
      errors++;
      $display("FAIL abort_reset tm=%0d qr=(%0d,%0d) busy=%b tick=%b x0=%0d y3=%0d",
               tm, qr_x, qr_y, busy, frame_tick, pt_x[0], pt_y[3]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (frame_tick !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_tick_after_release cyc=%0d tick=%b busy=%b", c, frame_tick, busy);
      end
    end
    do_frame(1'b0);
    checks++;
    if (tm !== 20'd1 || qr_x !== 10'd1) begin
      errors++;
      $display("FAIL first_after_abort tm=%0d qr_x=%0d want 1,1", tm, qr_x);
    end
  endtask

  initial begin
    model_reset();
    tick3_seen = 0;
    test_reset();
    test_first_frame();
    test_long_run();
    test_pause_step();
    test_skip_line();
    test_frame_div();
    test_reset_mid_update();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
